// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-unit result FIFOs drained round-robin onto up to four
// ROB writeback lanes, with stop freeze and branch-mispredict squash.
module wb_arbiter #(
    parameter int NUM_EU     = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stop,
    input  logic [NUM_EU-1:0] eu_valid,
    input  logic [6:0]        eu_tag  [0:NUM_EU-1],
    input  logic [31:0]       eu_data [0:NUM_EU-1],
    output logic [NUM_EU-1:0] eu_ready,
    output logic [3:0]        wb_valid,
    output logic [7:0]        wb_tag  [0:3],
    output logic [31:0]       wb_data [0:3],
    input  logic [6:0]        rob_head,
    input  logic              bp_mispredict,
    input  logic [6:0]        bp_rob_tag
);
    localparam int RR_W  = $clog2(NUM_EU);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [6:0]        tag_q  [NUM_EU][FIFO_DEPTH];
    logic [31:0]       data_q [NUM_EU][FIFO_DEPTH];
    logic [6:0]        tag_d  [NUM_EU][FIFO_DEPTH];
    logic [31:0]       data_d [NUM_EU][FIFO_DEPTH];
    logic [CNT_W-1:0]  cnt_q  [NUM_EU];
    logic [CNT_W-1:0]  cnt_d  [NUM_EU];
    logic [RR_W-1:0]   rr_q, rr_d;
    logic [NUM_EU-1:0] nonempty, pop;
    logic [RR_W-1:0]   pos  [NUM_EU];
    logic [RR_W-1:0]   rank [NUM_EU];
    logic [RR_W-1:0]   last, last_pos;

    // Distance from the ROB head, mod 64, orders tags by age across wrap-around.
    function automatic logic younger(input logic [6:0] t, input logic [6:0] b,
                                     input logic [6:0] h);
        return 6'(t - h) > 6'(b - h);
    endfunction

    always_comb begin
        for (int j = 0; j < NUM_EU; j++) begin
            nonempty[j] = (cnt_q[j] != '0);
            eu_ready[j] = (cnt_q[j] < CNT_W'(FIFO_DEPTH));
            if (RR_W'(j) >= rr_q) pos[j] = RR_W'(j) - rr_q;
            else                  pos[j] = RR_W'(j) + RR_W'(NUM_EU) - rr_q;
        end
        // A unit's lane is the number of non-empty units ahead of it in scan order.
        for (int j = 0; j < NUM_EU; j++) begin
            rank[j] = '0;
            for (int m = 0; m < NUM_EU; m++)
                if (nonempty[m] && pos[m] < pos[j]) rank[j] = rank[j] + RR_W'(1);
        end
    end

    always_comb begin
        wb_valid = '0;
        pop      = '0;
        last     = '0;
        last_pos = '0;
        for (int l = 0; l < 4; l++) begin
            wb_tag[l]  = '0;
            wb_data[l] = '0;
        end
        for (int l = 0; l < 4; l++)
            for (int j = 0; j < NUM_EU; j++)
                if (nonempty[j] && rank[j] == RR_W'(l) && !stop &&
                    !(bp_mispredict && younger(tag_q[j][0], bp_rob_tag, rob_head))) begin
                    wb_valid[l] = 1'b1;
                    wb_tag[l]   = {1'b0, tag_q[j][0]};
                    wb_data[l]  = data_q[j][0];
                    pop[j]      = 1'b1;
                end
        for (int j = 0; j < NUM_EU; j++)
            if (pop[j] && pos[j] >= last_pos) begin
                last_pos = pos[j];
                last     = RR_W'(j);
            end
        if (pop == '0)                      rr_d = rr_q;
        else if (last == RR_W'(NUM_EU - 1)) rr_d = '0;
        else                                rr_d = last + RR_W'(1);
    end

    // Next FIFO contents: drop popped head and squashed entries, compact, then append push.
    always_comb begin
        for (int j = 0; j < NUM_EU; j++) begin
            cnt_d[j] = '0;
            for (int s = 0; s < FIFO_DEPTH; s++) begin
                tag_d[j][s]  = tag_q[j][s];
                data_d[j][s] = data_q[j][s];
            end
            for (int s = 0; s < FIFO_DEPTH; s++)
                if (CNT_W'(s) < cnt_q[j] && !(s == 0 && pop[j]) &&
                    !(bp_mispredict && younger(tag_q[j][s], bp_rob_tag, rob_head))) begin
                    for (int d = 0; d < FIFO_DEPTH; d++)
                        if (cnt_d[j] == CNT_W'(d)) begin
                            tag_d[j][d]  = tag_q[j][s];
                            data_d[j][d] = data_q[j][s];
                        end
                    cnt_d[j] = cnt_d[j] + CNT_W'(1);
                end
            if (eu_valid[j] && eu_ready[j] &&
                !(bp_mispredict && younger(eu_tag[j], bp_rob_tag, rob_head))) begin
                for (int d = 0; d < FIFO_DEPTH; d++)
                    if (cnt_d[j] == CNT_W'(d)) begin
                        tag_d[j][d]  = eu_tag[j];
                        data_d[j][d] = eu_data[j];
                    end
                cnt_d[j] = cnt_d[j] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < NUM_EU; j++) cnt_q[j] <= '0;
            rr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rr_q  <= rr_d;
        end
    end

    // Payload storage is only meaningful below the count, so it carries no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter, checked against a queue-based
// reference model of the writeback arbitration rules.
module tb_wb_arbiter;
    localparam int N = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stop = 1'b0;
    logic [N-1:0] eu_valid = '0;
    logic [6:0]  eu_tag  [0:N-1];
    logic [31:0] eu_data [0:N-1];
    logic [N-1:0] eu_ready;
    logic [3:0]  wb_valid;
    logic [7:0]  wb_tag  [0:3];
    logic [31:0] wb_data [0:3];
    logic [6:0]  rob_head = '0;
    logic        bp_mispredict = 1'b0;
    logic [6:0]  bp_rob_tag = '0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [38:0] q [N][$];
    int rr_m = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.NUM_EU(N), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .stop(stop),
        .eu_valid(eu_valid), .eu_tag(eu_tag), .eu_data(eu_data), .eu_ready(eu_ready),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .rob_head(rob_head), .bp_mispredict(bp_mispredict), .bp_rob_tag(bp_rob_tag)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic bit is_younger(int t, int b, int h);
        return ((t - h) & 63) > ((b - h) & 63);
    endfunction

    // Compare outputs against the model for the current inputs, then advance the model.
    task automatic model_step();
        bit rdy [N];
        bit popm [N];
        int lanes = 0;
        int last = 0;
        bit any = 0;
        int u;
        logic [3:0]  ev = '0;
        logic [7:0]  et [4];
        logic [31:0] ed [4];
        logic [38:0] e;
        logic [38:0] keep [$];
        logic [6:0]  t;
        for (int l = 0; l < 4; l++) begin et[l] = '0; ed[l] = '0; end
        for (int j = 0; j < N; j++) begin
            rdy[j]  = q[j].size() < 2;
            popm[j] = 0;
            check($sformatf("ready%0d", j), 64'(eu_ready[j]), 64'(rdy[j]));
        end
        for (int k = 0; k < N; k++) begin
            u = (rr_m + k) % N;
            if (q[u].size() > 0 && lanes < 4) begin
                e = q[u][0];
                t = e[38:32];
                if (!stop && !(bp_mispredict && is_younger(int'(t), int'(bp_rob_tag), int'(rob_head)))) begin
                    ev[lanes] = 1'b1;
                    et[lanes] = {1'b0, t};
                    ed[lanes] = e[31:0];
                    popm[u] = 1;
                    last = u;
                    any = 1;
                end
                lanes++;
            end
        end
        check("wb_valid", 64'(wb_valid), 64'(ev));
        for (int l = 0; l < 4; l++) begin
            check($sformatf("wb_tag%0d", l), 64'(wb_tag[l]), 64'(et[l]));
            check($sformatf("wb_data%0d", l), 64'(wb_data[l]), 64'(ed[l]));
        end
        for (int j = 0; j < N; j++) begin
            if (popm[j]) void'(q[j].pop_front());
            if (bp_mispredict) begin
                keep = {};
                for (int i = 0; i < q[j].size(); i++) begin
                    e = q[j][i];
                    t = e[38:32];
                    if (!is_younger(int'(t), int'(bp_rob_tag), int'(rob_head))) keep.push_back(e);
                end
                q[j] = keep;
            end
            if (eu_valid[j] && rdy[j] &&
                !(bp_mispredict && is_younger(int'(eu_tag[j]), int'(bp_rob_tag), int'(rob_head))))
                q[j].push_back({eu_tag[j], eu_data[j]});
        end
        if (any) rr_m = (last + 1) % N;
    endtask

    task automatic cycle();
        #1;
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        eu_valid = '0;
        stop = 1'b0;
        bp_mispredict = 1'b0;
    endtask

    task automatic push(input int u, input int t, input logic [31:0] d);
        eu_valid[u] = 1'b1;
        eu_tag[u]   = 7'(t);
        eu_data[u]  = d;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        for (int j = 0; j < N; j++) q[j].delete();
        rr_m = 0;
        #1;
        check("rst_wb_valid", 64'(wb_valid), 64'h0);
        check("rst_ready", 64'(eu_ready), 64'h3f);
        check("rst_tag0", 64'(wb_tag[0]), 64'h0);
        check("rst_data0", 64'(wb_data[0]), 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        for (int j = 0; j < N; j++) begin eu_tag[j] = '0; eu_data[j] = '0; end
        #2;
        do_reset();

        // Single result, one cycle of latency, then empty
        push(0, 5, 32'hDEADBEEF);
        cycle();
        idle();
        #1;
        check("single_valid", 64'(wb_valid), 64'h1);
        check("single_tag", 64'(wb_tag[0]), 64'h05);
        check("single_data", 64'(wb_data[0]), 64'hDEADBEEF);
        cycle();
        #1;
        check("single_after", 64'(wb_valid), 64'h0);
        cycle();

        // Round-robin over six loaded units
        do_reset();
        stop = 1'b1;
        for (int j = 0; j < N; j++) push(j, 10 + j, 32'(100 + j));
        cycle();
        idle();
        #1;
        check("rr_c1_valid", 64'(wb_valid), 64'hf);
        for (int l = 0; l < 4; l++) check($sformatf("rr_c1_tag%0d", l), 64'(wb_tag[l]), 64'(10 + l));
        cycle();
        #1;
        check("rr_c2_valid", 64'(wb_valid), 64'h3);
        check("rr_c2_tag0", 64'(wb_tag[0]), 64'd14);
        check("rr_c2_tag1", 64'(wb_tag[1]), 64'd15);
        cycle();
        stop = 1'b1;
        push(5, 50, 32'h5);
        push(0, 51, 32'h0);
        cycle();
        idle();
        #1;
        check("rr_wrap_lane0", 64'(wb_tag[0]), 64'd51);
        check("rr_wrap_lane1", 64'(wb_tag[1]), 64'd50);
        cycle();

        // Backpressure under stop; producer holds the third result
        stop = 1'b1;
        push(2, 20, 32'h1);
        cycle();
        push(2, 21, 32'h2);
        cycle();
        push(2, 22, 32'h3);
        #1;
        check("bp_ready2", 64'(eu_ready[2]), 64'h0);
        cycle();
        stop = 1'b0;
        cycle();
        cycle();
        idle();
        for (int c = 0; c < 3; c++) cycle();

        // Mispredict with tag wrap-around
        do_reset();
        stop = 1'b1;
        push(0, 61, 32'hA0);
        push(1, 63, 32'hA1);
        push(2, 1, 32'hA2);
        push(3, 62, 32'hA3);
        cycle();
        idle();
        rob_head = 7'd60;
        bp_rob_tag = 7'd62;
        bp_mispredict = 1'b1;
        #1;
        check("wrap_valid", 64'(wb_valid), 64'h9);
        check("wrap_tag0", 64'(wb_tag[0]), 64'd61);
        check("wrap_tag3", 64'(wb_tag[3]), 64'd62);
        cycle();
        bp_mispredict = 1'b0;
        #1;
        check("wrap_after_valid", 64'(wb_valid), 64'h0);
        check("wrap_after_ready", 64'(eu_ready), 64'h3f);
        cycle();
        cycle();

        // Flush compaction: younger head removed, older tail moves up
        do_reset();
        stop = 1'b1;
        push(1, 40, 32'h40);
        cycle();
        push(1, 30, 32'h30);
        cycle();
        eu_valid = '0;
        rob_head = 7'd20;
        bp_rob_tag = 7'd35;
        bp_mispredict = 1'b1;
        cycle();
        idle();
        #1;
        check("compact_ready1", 64'(eu_ready[1]), 64'h1);
        check("compact_valid", 64'(wb_valid), 64'h1);
        check("compact_tag", 64'(wb_tag[0]), 64'd30);
        cycle();
        cycle();

        // Asynchronous reset in the middle of a drain
        do_reset();
        stop = 1'b1;
        push(0, 3, 32'h3);
        push(1, 4, 32'h4);
        push(2, 5, 32'h5);
        cycle();
        idle();
        #1;
        check("arst_pre_valid", 64'(wb_valid), 64'h7);
        #1;
        reset = 1'b0;
        #1;
        check("arst_valid", 64'(wb_valid), 64'h0);
        check("arst_ready", 64'(eu_ready), 64'h3f);
        for (int j = 0; j < N; j++) q[j].delete();
        rr_m = 0;
        @(negedge clk);
        reset = 1'b1;
        cycle();
        cycle();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            stop = ($urandom % 5) == 0;
            bp_mispredict = ($urandom % 8) == 0;
            bp_rob_tag = 7'($urandom);
            rob_head = 7'($urandom);
            eu_valid = N'($urandom);
            for (int j = 0; j < N; j++) begin
                eu_tag[j]  = 7'($urandom);
                eu_data[j] = $urandom;
            end
            cycle();
        end
        idle();
        for (int c = 0; c < 4; c++) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter feeding the ROB writeback port; this block is the producer side of that interface.
- Collects completed results from NUM_EU execution units, each through a valid/ready handshake.
- Buffers results per unit in a 2-entry FIFO.
- Each cycle, drives up to 4 results onto wb_valid/wb_tag/wb_data in round-robin order.
- Honours the ROB stop freeze and discards results squashed by a branch mispredict.

Parameters:
- NUM_EU, 6, number of execution-unit result sources (4..8).
- FIFO_DEPTH, 2, result buffer entries per execution unit.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- stop  in  1  system pause (the same stop the ROB sees).
- eu_valid  in  NUM_EU  result valid, per unit.
- eu_tag  in  7 x NUM_EU  ROB tag of the result (array eu_tag[0:NUM_EU-1]).
- eu_data  in  32 x NUM_EU  result data.
- eu_ready  out  NUM_EU  per-unit FIFO can accept.
- wb_valid  out  4  writeback lane valid.
- wb_tag  out  8 x 4  ROB tag, zero-extended from 7 bits.
- wb_data  out  32 x 4  writeback data.
- rob_head  in  7  ROB head_ptr (oldest entry), used for age compare.
- bp_mispredict  in  1  branch mispredict flush.
- bp_rob_tag  in  7  ROB tag of the mispredicted branch.

Behaviour:
- Reset (reset==0, asynchronous):
  - All FIFOs empty; round-robin pointer rr=0.
  - eu_ready all 1.
  - wb_valid=0; wb_tag and wb_data outputs read 0.
- Push: eu_valid[i]&&eu_ready[i] at a clk edge writes {tag,data} into FIFO i.
  - eu_ready[i] = (count_i < FIFO_DEPTH). It does not depend on a same-cycle pop.
  - Pushes are accepted even while stop==1.
- Lane selection (combinational from FIFO heads):
  - Scan units in order rr, rr+1, ... (mod NUM_EU).
  - The first up to 4 non-empty units get lanes 0,1,2,3 in scan order.
  - Unused lanes have wb_valid=0 and tag/data 0.
  - At most one entry leaves each unit per cycle.
- Latency: a result pushed at edge N appears on a lane no earlier than the cycle after edge N. There is no input-to-output bypass.
- Pop:
  - At the clock edge, every lane with wb_valid=1 pops its unit's head.
  - rr <= (index of last granted unit + 1) mod NUM_EU.
  - If nothing is granted, rr holds.
- stop==1:
  - wb_valid forced 0.
  - No pops; rr holds.
  - The FIFOs still accept pushes up to full.
- Age rule: tag T is younger than branch B iff ((T - rob_head) mod 64) > ((B - rob_head) mod 64). The branch's own tag (T==B) is kept.
- bp_mispredict==1 (acts regardless of stop):
  - Same cycle: lanes whose tag is younger than B are masked to wb_valid=0 and are not popped.
  - Same cycle: lanes whose tag is not younger are written back and popped as normal.
  - At the edge: every buffered entry younger than B is deleted from every FIFO.
  - Surviving entries are compacted to the head, keeping their relative order.
  - A push in the same cycle with a younger tag is accepted (ready handshake completes) and discarded.
  - A push in the same cycle with an older tag is stored.
- Simultaneous pop and push on one unit: allowed only when count_i < FIFO_DEPTH. Count is unchanged; the new entry goes behind the remaining entries.
- Wrap-around: tag arithmetic is mod 64. rob_head near 63 with tags 0..5 must compare correctly.
- No duplicate-tag checking. The ROB marks done on any valid writeback.
- Output registers: none. Storage is the FIFO array, counters and rr only.

Test Plan:
- Single result: after reset, push eu0 tag=5 data=0xDEADBEEF → next cycle wb_valid=4'b0001, wb_tag[0]=8'h05, wb_data[0]=0xDEADBEEF; the following cycle wb_valid=0.
- Round-robin: all 6 units hold one entry (tags 10..15), rr=0 → cycle 1 lanes carry tags 10,11,12,13; cycle 2 lanes carry 14,15 with wb_valid=4'b0011; rr ends at 0.
- Backpressure: push eu2 three consecutive cycles with stop=1 → eu_ready[2]=0 after 2 accepts and the third is held by the producer; clear stop → 2 writebacks drain, then the third is accepted.
- Mispredict with wrap: rob_head=60, bp_rob_tag=62, FIFOs hold tags 61, 63, 1, 62 → only 61 and 62 are written back; 63 and 1 never appear; eu_ready returns to 1.
- Flush compaction: eu1 FIFO holds head=40 (younger), tail=30 (older), rob_head=20, bp_rob_tag=35 → after flush eu1 count=1 and the next writeback is tag 30.
- Async reset: assert reset=0 mid-drain with 3 lanes valid → wb_valid=0 immediately, without waiting for clk; after release all eu_ready=1 and no stale writebacks appear.
